seq_1011_tx: RTL and testbench
==============================

# seq_1011_tx

Serial frame transmitter: the transmit side of the 1011-preamble serial link.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits one bit per clock: fixed preamble 1011, then the payload MSB-first, then an optional parity bit, then a run of idle zeros.
- Feeds the serial input of the team's Moore 1011 sequence detector, and is used to build link-level stimulus and loopback paths.

## Interface
- DATA_W, 8: payload width in bits, ≥ 1.
- GAP_BITS, 2: zero bits forced after each frame, ≥ 1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  payload offered.
- in_data  in  DATA_W  payload word; sampled only on the accept edge.
- in_ready  out  1  transmitter can accept a word.
- x_out  out  1  serial output bit, registered.
- tx_busy  out  1  frame or gap in progress.
- frame_done  out  1  one-cycle pulse marking the last frame bit.

## Operation
- States: IDLE, PRE, DATA, PAR, GAP.
- PAR is present only when parity is compiled in (see Configuration).
- Datapath registers:
  - shift register, DATA_W bits;
  - bit counter, ceil(log2(max(4, DATA_W, GAP_BITS))) bits;
  - parity accumulator.
- Accept: at a rising edge where in_valid=1 and in_ready=1:
  - in_data is copied to the shift register;
  - the counter is cleared;
  - state moves IDLE→PRE.
- IDLE:
  - in_ready=1 (forced 0 while rst=1);
  - x_out=0, tx_busy=0;
  - in_valid=0 keeps the block in IDLE.
- PRE:
  - x_out presents 1,0,1,1 on four consecutive cycles;
  - then goes to DATA.
- DATA:
  - x_out = shift register MSB;
  - the register shifts left each cycle;
  - the parity accumulator XORs in each presented bit;
  - after DATA_W bits, goes to PAR if enabled, else to GAP.
- PAR:
  - one cycle; x_out = even-parity bit, so ones in payload plus parity is even;
  - then goes to GAP.
- GAP:
  - x_out=0 for GAP_BITS cycles;
  - then returns to IDLE.
- tx_busy=1 in PRE, DATA, PAR and GAP. in_ready=0 in those states.
- frame_done=1 exactly during the cycle x_out carries the last payload bit (no parity) or the parity bit (parity enabled).
- in_data changes after the accept edge have no effect on the frame in flight.
- Payload is not scrambled or stuffed. A 1011 pattern inside the payload is legal and is the receiver's concern.
- Reset mid-frame:
  - the next edge with rst=1 aborts the frame;
  - state=IDLE, x_out=0, tx_busy=0, frame_done=0;
  - in_ready=1 on the first cycle after rst deasserts.
- Undefined state encodings recover to IDLE with x_out=0.

## Timing
- Reset values: x_out=0, tx_busy=0, frame_done=0, state IDLE. in_ready=0 while rst=1.
- Accept at edge k:
  - preamble on x_out in cycles k+1..k+4;
  - payload in cycles k+5..k+4+DATA_W;
  - parity at k+5+DATA_W (if enabled);
  - then GAP_BITS zero cycles.
- Let P=1 with parity, else 0. in_ready returns high in cycle k+5+DATA_W+P+GAP_BITS.
- Minimum frame period is therefore 5+DATA_W+P+GAP_BITS cycles (15 at defaults, no parity). The IDLE cycle contributes one further zero on the line.
- in_ready depends only on state and rst, never on in_valid: no combinational path from in_valid to in_ready.
- in_valid may be held high continuously: frames are then sent back-to-back at the minimum period.

## Configuration
- SEQ_TX_PARITY_EN defined:
  - PAR state and parity accumulator are built;
  - frame length = 4+DATA_W+1 bits;
  - frame_done marks the parity bit.
- SEQ_TX_PARITY_EN not defined:
  - no PAR state and no accumulator logic;
  - DATA goes straight to GAP;
  - frame_done marks the last payload bit.

## Test plan
- Reset check: rst=1 for 3 cycles, in_valid=1 → x_out=0, tx_busy=0, in_ready=0, no frame starts. After release, in_ready=1.
- Single frame, defaults, no parity: accept 8'hA5 at edge k.
  - x_out in cycles k+1..k+14 = 1,0,1,1,1,0,1,0,0,1,0,1,0,0;
  - frame_done high only in cycle k+12;
  - in_ready=1 in cycle k+15.
- Parity build: 8'hA5 → parity bit 0 at cycle k+13. 8'h01 → parity bit 1 at cycle k+13. In both, frame_done is only at k+13 and in_ready returns at k+16.
- Back-to-back: in_valid held high with words 8'hFF then 8'h00 → second preamble starts exactly 15 cycles after the first; no word lost or duplicated.
- Mid-frame reset: accept 8'hC3, assert rst during the 3rd payload bit.
  - next cycle: x_out=0, tx_busy=0;
  - after release, a new frame with 8'h3C is sent complete and correct.
- Loopback: x_out feeds the 1011 detector. Three frames of 8'h00 → exactly one detection per frame, one cycle after the 4th preamble bit.

Source files
------------

// File: rtl/seq_1011_tx.sv
// Serial frame transmitter for the 1011-preamble link.
// Each accepted word goes out as: preamble 1011, payload MSB-first, an optional
// even-parity bit, then GAP_BITS idle zeros.
// Define SEQ_TX_PARITY_EN to build the parity bit (PAR state and accumulator).
module seq_1011_tx #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              x_out,
    output logic              tx_busy,
    output logic              frame_done
);

    localparam int unsigned MaxA = (DATA_W > 4) ? DATA_W : 4;
    localparam int unsigned MaxN = (GAP_BITS > MaxA) ? GAP_BITS : MaxA;
    localparam int unsigned CntW = $clog2(MaxN);

    localparam logic [CntW-1:0] PreLast  = CntW'(3);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_BITS - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPre  = 3'd1,
        StData = 3'd2,
`ifdef SEQ_TX_PARITY_EN
        StPar  = 3'd3,
`endif
        StGap  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_d;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_d;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_d;
    logic              r_x_out;
    logic              w_x_d;
    logic              r_done;
    logic              w_done_d;
`ifdef SEQ_TX_PARITY_EN
    logic              r_par;
    logic              w_par_d;
`endif

    // Next-state, counter, shift register and parity accumulator.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_shift_d = r_shift;
`ifdef SEQ_TX_PARITY_EN
        w_par_d   = r_par;
`endif
        case (r_state)
            StIdle: begin
                // in_ready is 1 whenever IDLE and not in reset; reset wins in the register.
                if (in_valid) begin
                    w_state_d = StPre;
                    w_cnt_d   = '0;
                    w_shift_d = in_data;
`ifdef SEQ_TX_PARITY_EN
                    w_par_d   = 1'b0;
`endif
                end
            end
            StPre: begin
                w_cnt_d = r_cnt + CntOne;
                if (r_cnt == PreLast) begin
                    w_state_d = StData;
                    w_cnt_d   = '0;
                end
            end
            StData: begin
                w_shift_d = r_shift << 1;
                w_cnt_d   = r_cnt + CntOne;
`ifdef SEQ_TX_PARITY_EN
                w_par_d   = r_par ^ r_shift[DATA_W-1];
`endif
                if (r_cnt == DataLast) begin
                    w_cnt_d = '0;
`ifdef SEQ_TX_PARITY_EN
                    w_state_d = StPar;
`else
                    w_state_d = StGap;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            StPar: begin
                w_state_d = StGap;
                w_cnt_d   = '0;
            end
`endif
            StGap: begin
                w_cnt_d = r_cnt + CntOne;
                if (r_cnt == GapLast) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        w_x_d    = 1'b0;
        w_done_d = 1'b0;
        case (w_state_d)
            StPre: begin
                // Preamble 1,0,1,1: only position 1 is a zero.
                w_x_d = (w_cnt_d != CntOne);
            end
            StData: begin
                w_x_d = w_shift_d[DATA_W-1];
`ifndef SEQ_TX_PARITY_EN
                w_done_d = (w_cnt_d == DataLast);
`endif
            end
`ifdef SEQ_TX_PARITY_EN
            StPar: begin
                w_x_d    = w_par_d;
                w_done_d = 1'b1;
            end
`endif
            default: begin
                w_x_d    = 1'b0;
                w_done_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_shift <= '0;
            r_x_out <= 1'b0;
            r_done  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_shift <= w_shift_d;
            r_x_out <= w_x_d;
            r_done  <= w_done_d;
`ifdef SEQ_TX_PARITY_EN
            r_par   <= w_par_d;
`endif
        end
    end

    assign x_out      = r_x_out;
    assign frame_done = r_done;
    assign tx_busy    = (r_state != StIdle);
    // Depends on state and rst only, never on in_valid.
    assign in_ready   = (r_state == StIdle) && !rst;

endmodule

// File: tb/tb_seq_1011_tx.sv
// Self-checking bench for seq_1011_tx with a per-cycle scoreboard of expected line bits.
module tb_seq_1011_tx;

    localparam int unsigned DataW = 8;
    localparam int unsigned GapB  = 2;
`ifdef SEQ_TX_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [DataW-1:0] in_data;
    logic             in_ready;
    logic             x_out;
    logic             tx_busy;
    logic             frame_done;

    typedef struct packed {
        logic x;
        logic fd;
        logic pre4;
    } exp_t;

    exp_t q[$];
    exp_t e_cur;
    logic busy_exp;
    logic mon_en  = 1'b0;
    logic loop_en = 1'b0;
    logic [3:0] hist = '0;
    int   det_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    seq_1011_tx #(
        .DATA_W   (DataW),
        .GAP_BITS (GapB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .x_out      (x_out),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic x, input logic fd, input logic pre4);
        exp_t e;
        e.x    = x;
        e.fd   = fd;
        e.pre4 = pre4;
        return e;
    endfunction

    // Expected line contents for one frame, starting the cycle after the accept edge.
    task automatic push_frame(input logic [DataW-1:0] w);
        logic [3:0] pre;
        pre = 4'b1011;
        for (int i = 0; i < 4; i++) q.push_back(mk(pre[3-i], 1'b0, (i == 3)));
        for (int i = 0; i < DataW; i++)
            q.push_back(mk(w[DataW-1-i], (i == DataW - 1) && !ParEn, 1'b0));
        if (ParEn) q.push_back(mk(^w, 1'b1, 1'b0));
        for (int i = 0; i < GapB; i++) q.push_back(mk(1'b0, 1'b0, 1'b0));
    endtask

    // Offer a word; on accept, queue its frame and scramble in_data.
    task automatic send(input logic [DataW-1:0] w, input logic hold);
        logic got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("accept", {31'd0, got}, 32'd1);
        if (got) begin
            @(posedge clk);
            #1;
            push_frame(w);
            in_valid = hold;
            in_data  = DataW'($urandom);
        end
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (q.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("idle_wait", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every cycle against the scoreboard; empty queue means idle line.
    always @(negedge clk) begin
        if (mon_en) begin
            busy_exp = (q.size() > 0);
            if (busy_exp) e_cur = q.pop_front();
            else e_cur = '0;
            check_eq("x_out", {31'd0, x_out}, {31'd0, e_cur.x});
            check_eq("frame_done", {31'd0, frame_done}, {31'd0, e_cur.fd});
            check_eq("tx_busy", {31'd0, tx_busy}, {31'd0, busy_exp});
            check_eq("in_ready", {31'd0, in_ready}, {31'd0, !busy_exp && !rst});
            hist = {hist[2:0], x_out};
            if (loop_en && hist == 4'b1011) begin
                det_cnt++;
                check_eq("det_pos", {31'd0, e_cur.pre4}, 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        send(8'hA5, 1'b0);
        wait_idle();
        send(8'h01, 1'b0);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            send(DataW'($urandom), 1'b0);
            wait_idle();
        end

        // Back-to-back with in_valid held high.
        send(8'hFF, 1'b1);
        send(8'h00, 1'b0);
        wait_idle();

        // Reset during the third payload bit.
        send(8'hC3, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(8'h3C, 1'b0);
        wait_idle();

        // Loopback through a 1011 detector model.
        repeat (4) @(posedge clk);
        #1;
        det_cnt = 0;
        loop_en = 1'b1;
        for (int i = 0; i < 3; i++) send(8'h00, 1'b0);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        loop_en = 1'b0;
        check_eq("loop_det_count", det_cnt, 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
